// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// State encoding, debounce defaults and the display tick rate.
package stopwatch_pkg;

  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;
  localparam int unsigned CNT_W_DEFAULT     = 20;
  localparam int unsigned TICK_HZ           = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_LAP    = 2'd3
  } state_e;

  // One bit per button, used for both debounced levels and press pulses
  typedef struct packed {
    logic clear;
    logic start;
    logic lap;
  } btn_t;

  function automatic logic is_running(state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/display controls of the stopwatch controller.
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_lap;
  logic btn_clear;
  logic tick;
  logic count_en;
  logic count_clr;
  logic lap_hold;
  logic running;

  modport master (
    output btn_start, btn_lap, btn_clear, tick,
    input  count_en, count_clr, lap_hold, running
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear, tick,
    output count_en, count_clr, lap_hold, running
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw push button -> 2-FF synchroniser -> debounced level -> 1-cycle press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Level flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: debounces three buttons and
// drives counter enable/clear plus the display lap-freeze flag.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  btn_t   press;
  state_e state_q;
  state_e state_d;
  logic   clr_acc;
  logic   count_en_c;
  logic   count_clr_c;
  logic   lap_hold_c;
  logic   running_c;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_start),
    .level  (),
    .press  (press.start)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_lap (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_lap),
    .level  (),
    .press  (press.lap)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_clear),
    .level  (),
    .press  (press.clear)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Priority clear > start > lap; an ignored press lets the next one act
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press.clear)      clr_acc = 1'b1;
        else if (press.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press.start)      state_d = ST_PAUSED;
        else if (press.lap)   state_d = ST_LAP;
      end
      ST_LAP: begin
        if (press.start)      state_d = ST_PAUSED;
        else if (press.lap)   state_d = ST_RUN;
      end
      ST_PAUSED: begin
        if (press.clear) begin
          clr_acc = 1'b1;
          state_d = ST_IDLE;
        end else if (press.start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick gating uses the pre-transition state; status flags follow the new one
  always_comb begin
    count_en_c  = 1'b0;
    count_clr_c = 1'b0;
    lap_hold_c  = 1'b0;
    running_c   = 1'b0;
    count_en_c  = bus.tick & is_running(state_q);
    count_clr_c = clr_acc;
    lap_hold_c  = (state_d == ST_LAP);
    running_c   = is_running(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.count_en  <= 1'b0;
      bus.count_clr <= 1'b0;
      bus.lap_hold  <= 1'b0;
      bus.running   <= 1'b0;
    end else begin
      bus.count_en  <= count_en_c;
      bus.count_clr <= count_clr_c;
      bus.lap_hold  <= lap_hold_c;
      bus.running   <= running_c;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int unsigned DB          = 4;
  localparam int unsigned TICK_PERIOD = 10;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_LAP    = 3;
  // next state per [state][action], action 0=clear 1=start 2=lap, -1 = ignored
  localparam int TRANS [4][3] = '{'{0, 1, -1}, '{-1, 2, 3}, '{0, 1, -1}, '{-1, 2, 1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int tcnt = 0;
  int n;
  bit tick_on = 1'b0;

  // ---------------- reference model ----------------
  logic [2:0]  raw;
  logic [DB:0] mh [3];
  logic [2:0]  mlvl, mlvlp, mprs;
  int          mst;
  logic        m_en, m_clr, m_lap, m_run;

  assign raw = {bus.btn_lap, bus.btn_start, bus.btn_clear};

  // A button level changes once its last DB synchronised samples all disagree
  function automatic logic settled_flip(logic [DB:0] h, logic l);
    for (int i = 1; i <= DB; i++) if (h[i] == l) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int act(int s, logic [2:0] p);
    for (int a = 0; a < 3; a++) if (p[a] && TRANS[s][a] >= 0) return a;
    return -1;
  endfunction

  function automatic int nxt(int s, logic [2:0] p);
    int a = act(s, p);
    return (a < 0) ? s : TRANS[s][a];
  endfunction

  function automatic logic counting(int s);
    return (s == M_RUN) || (s == M_LAP);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 3; b++) mh[b] <= '0;
      mlvl  <= '0;
      mlvlp <= '0;
      mprs  <= '0;
      mst   <= M_IDLE;
      m_en  <= 1'b0;
      m_clr <= 1'b0;
      m_lap <= 1'b0;
      m_run <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        mh[b] <= {mh[b][DB-1:0], raw[b]};
        if (settled_flip(mh[b], mlvl[b])) mlvl[b] <= ~mlvl[b];
      end
      mlvlp <= mlvl;
      mprs  <= mlvl & ~mlvlp;
      mst   <= nxt(mst, mprs);
      m_en  <= bus.tick & counting(mst);
      m_clr <= (act(mst, mprs) == 0);
      m_lap <= (nxt(mst, mprs) == M_LAP);
      m_run <= counting(nxt(mst, mprs));
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: compare every output with the model, then advance the tick source
  task automatic cyc();
    @(negedge clk);
    chk("count_en",  32'(bus.count_en),  32'(m_en));
    chk("count_clr", 32'(bus.count_clr), 32'(m_clr));
    chk("lap_hold",  32'(bus.lap_hold),  32'(m_lap));
    chk("running",   32'(bus.running),   32'(m_run));
    if (bus.count_en === 1'b1)  en_cnt++;
    if (bus.count_clr === 1'b1) clr_cnt++;
    bus.tick = tick_on && (tcnt == TICK_PERIOD - 1);
    tcnt = (tcnt + 1) % TICK_PERIOD;
  endtask

  task automatic set_btns(input logic [2:0] v);
    bus.btn_clear = v[0];
    bus.btn_start = v[1];
    bus.btn_lap   = v[2];
  endtask

  // Clean press: held long enough to register, then released long enough to settle
  task automatic press(input logic [2:0] which);
    set_btns(which);
    repeat (8) cyc();
    set_btns(3'b000);
    repeat (10) cyc();
  endtask

  task automatic ticks_window(input int len);
    en_cnt  = 0;
    tcnt    = 0;
    tick_on = 1'b1;
    repeat (len) cyc();
    tick_on = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_btns(3'b000);
    bus.tick = 1'b0;
    #1 rst = 1'b0;

    // reset held while buttons toggle
    for (int i = 0; i < 3; i++) begin
      set_btns(3'(i + 5));
      cyc();
    end
    chk("rst_count_en",  32'(bus.count_en),  32'd0);
    chk("rst_count_clr", 32'(bus.count_clr), 32'd0);
    chk("rst_lap_hold",  32'(bus.lap_hold),  32'd0);
    chk("rst_running",   32'(bus.running),   32'd0);
    set_btns(3'b000);
    rst = 1'b1;
    repeat (4) cyc();

    // lone 3-cycle glitch is dropped
    bus.btn_start = 1'b1;
    repeat (3) cyc();
    bus.btn_start = 1'b0;
    repeat (15) cyc();
    chk("glitch_running", 32'(bus.running), 32'd0);

    // bounce: high 3, low 1, high 10 -> one press, running 8 cycles after final rise
    bus.btn_start = 1'b1;
    repeat (3) cyc();
    bus.btn_start = 1'b0;
    cyc();
    bus.btn_start = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 10) bus.btn_start = 1'b0;
      if (n == 0 && bus.running === 1'b1) n = i;
    end
    chk("bounce_latency", 32'(n), 32'd8);
    chk("bounce_single",  32'(bus.running), 32'd1);

    // back to IDLE, then run for 5 ticks and pause
    press(3'b010);
    press(3'b001);
    chk("to_idle_running", 32'(bus.running), 32'd0);
    press(3'b010);
    chk("run_running", 32'(bus.running), 32'd1);
    ticks_window(52);
    chk("run_en_count", 32'(en_cnt), 32'd5);
    press(3'b010);
    chk("pause_running", 32'(bus.running), 32'd0);
    ticks_window(52);
    chk("pause_en_count", 32'(en_cnt), 32'd0);

    // lap freezes display but counting continues
    press(3'b010);
    press(3'b100);
    chk("lap_hold_on",  32'(bus.lap_hold), 32'd1);
    chk("lap_running",  32'(bus.running),  32'd1);
    ticks_window(52);
    chk("lap_en_count", 32'(en_cnt), 32'd5);
    press(3'b100);
    chk("lap_release",  32'(bus.lap_hold), 32'd0);
    chk("lap_rel_run",  32'(bus.running),  32'd1);
    press(3'b100);
    press(3'b010);
    chk("lap_start_hold", 32'(bus.lap_hold), 32'd0);
    chk("lap_start_run",  32'(bus.running),  32'd0);

    // clear ignored in RUN, accepted in PAUSED
    press(3'b010);
    clr_cnt = 0;
    press(3'b001);
    chk("clr_run_ignored", 32'(clr_cnt), 32'd0);
    chk("clr_run_running", 32'(bus.running), 32'd1);
    press(3'b010);
    clr_cnt = 0;
    press(3'b001);
    chk("clr_paused_pulses", 32'(clr_cnt), 32'd1);
    chk("clr_paused_running", 32'(bus.running), 32'd0);

    // simultaneous presses
    press(3'b010);
    press(3'b010);
    clr_cnt = 0;
    press(3'b011);
    chk("sim_clr_start_clr", 32'(clr_cnt), 32'd1);
    chk("sim_clr_start_run", 32'(bus.running), 32'd0);
    press(3'b010);
    press(3'b110);
    chk("sim_start_lap_run", 32'(bus.running),  32'd0);
    chk("sim_start_lap_hold", 32'(bus.lap_hold), 32'd0);

    // reset mid-lap with start held through release
    press(3'b010);
    press(3'b100);
    chk("pre_rst_lap", 32'(bus.lap_hold), 32'd1);
    bus.btn_start = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("async_rst_lap", 32'(bus.lap_hold), 32'd0);
    chk("async_rst_run", 32'(bus.running),  32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (n == 0 && bus.running === 1'b1) n = i;
    end
    chk("held_thru_rst_latency", 32'(n), 32'd8);
    bus.btn_start = 1'b0;
    repeat (10) cyc();

    // random button activity with ticks and one mid-run reset
    tick_on = 1'b1;
    for (int i = 0; i < 800; i++) begin
      cyc();
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: bus.btn_clear = ~bus.btn_clear;
          1: bus.btn_start = ~bus.btn_start;
          default: bus.btn_lap = ~bus.btn_lap;
        endcase
      end
      if (i == 400) rst = 1'b0;
      if (i == 402) rst = 1'b1;
    end
    tick_on = 1'b0;
    set_btns(3'b000);
    repeat (12) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
